// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer for the 6-bit CPU: fetches over a req/ack port into an
// internal IR, pulses ALU/register-file controls for one EXEC cycle, and keeps a flag register.
module control_sequencer #(
    parameter int PC_W     = 6,
    parameter int IMM_W    = 6,
    parameter int ALU_OP_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_ack,
    input  logic [3:0]          imem_opcode,
    input  logic [IMM_W-1:0]    imem_imm,
    input  logic                alu_cf,
    input  logic                alu_sf,
    input  logic                alu_zf,
    output logic [ALU_OP_W-1:0] op,
    output logic                imm_sel,
    output logic                reg_en,
    output logic [IMM_W-1:0]    imm,
    output logic [2:0]          flags,
    output logic                halted
);

    generate
        if (IMM_W < PC_W) begin : g_bad_imm_w
            $error("control_sequencer: IMM_W must be >= PC_W");
        end
        if (ALU_OP_W < 2) begin : g_bad_op_w
            $error("control_sequencer: ALU_OP_W must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    localparam logic [3:0] OPC_JMP  = 4'b1000;
    localparam logic [3:0] OPC_JS   = 4'b1001;
    localparam logic [3:0] OPC_JZ   = 4'b1010;
    localparam logic [3:0] OPC_JC   = 4'b1011;
    localparam logic [3:0] OPC_JNZ  = 4'b1100;
    localparam logic [3:0] OPC_CMP  = 4'b1101;
    localparam logic [3:0] OPC_HALT = 4'b1111;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [3:0]         ir_opcode_q, ir_opcode_d;
    logic [IMM_W-1:0]   ir_imm_q, ir_imm_d;
    logic [2:0]         flags_q, flags_d;

    logic               is_alu;
    logic               is_cmp;
    logic               is_halt;
    logic               jump_taken;

    // Instruction classification from the IR; jumps test the latched {cf, sf, zf}.
    always_comb begin
        is_alu     = ~ir_opcode_q[3];
        is_cmp     = (ir_opcode_q == OPC_CMP);
        is_halt    = (ir_opcode_q == OPC_HALT);
        jump_taken = 1'b0;
        case (ir_opcode_q)
            OPC_JMP: jump_taken = 1'b1;
            OPC_JS:  jump_taken = flags_q[1];
            OPC_JZ:  jump_taken = flags_q[0];
            OPC_JC:  jump_taken = flags_q[2];
            OPC_JNZ: jump_taken = ~flags_q[0];
            default: jump_taken = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (imem_ack) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = is_halt ? S_HALT : S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Output logic: controls are only ever non-zero during EXEC.
    always_comb begin
        imem_req = 1'b0;
        halted   = 1'b0;
        op       = '0;
        imm_sel  = 1'b0;
        reg_en   = 1'b0;
        case (state_q)
            S_FETCH: imem_req = 1'b1;
            S_EXEC: begin
                if (is_alu) begin
                    reg_en  = 1'b1;
                    op      = ALU_OP_W'(ir_opcode_q[1:0]);
                    imm_sel = ir_opcode_q[2];
                end else if (is_cmp) begin
                    op = ALU_OP_W'(2'b01);
                end
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state: IR capture, pc advance/jump and flag latch.
    always_comb begin
        pc_d        = pc_q;
        ir_opcode_d = ir_opcode_q;
        ir_imm_d    = ir_imm_q;
        flags_d     = flags_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    ir_opcode_d = imem_opcode;
                    ir_imm_d    = imem_imm;
                end
            end
            S_EXEC: begin
                if (is_alu || is_cmp) begin
                    flags_d = {alu_cf, alu_sf, alu_zf};
                end
                // HALT keeps pc on its own address.
                if (!is_halt) begin
                    if (jump_taken) begin
                        pc_d = ir_imm_q[PC_W-1:0];
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= '0;
            ir_opcode_q <= '0;
            ir_imm_q    <= '0;
            flags_q     <= '0;
        end else begin
            pc_q        <= pc_d;
            ir_opcode_q <= ir_opcode_d;
            ir_imm_q    <= ir_imm_d;
            flags_q     <= flags_d;
        end
    end

    assign imem_addr = pc_q;
    assign imm       = ir_imm_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed instruction table, hand-written
// HALT and mid-EXEC reset sequences, then random instructions against a program-level model.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       imem_req;
    logic [5:0] imem_addr;
    logic       imem_ack;
    logic [3:0] imem_opcode;
    logic [5:0] imem_imm;
    logic       alu_cf, alu_sf, alu_zf;
    logic [1:0] op;
    logic       imm_sel;
    logic       reg_en;
    logic [5:0] imm;
    logic [2:0] flags;
    logic       halted;

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural model: pc, {cf,sf,zf} and halt status only.
    logic [5:0] m_pc;
    logic [2:0] m_flags;
    logic       m_halted;

    typedef struct {
        logic [3:0] opc;
        logic [5:0] imm_v;
        int         wait_c;
        logic [2:0] alu_fl;
        logic [5:0] exp_pc;
        logic [2:0] exp_flags;
    } vec_t;

    vec_t tbl[21];

    control_sequencer #(.PC_W(6), .IMM_W(6), .ALU_OP_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_opcode (imem_opcode),
        .imem_imm    (imem_imm),
        .alu_cf      (alu_cf),
        .alu_sf      (alu_sf),
        .alu_zf      (alu_zf),
        .op          (op),
        .imm_sel     (imm_sel),
        .reg_en      (reg_en),
        .imm         (imm),
        .flags       (flags),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Runs one instruction starting at a falling edge with the DUT in FETCH.
    task automatic run_instr(input logic [3:0] opc, input logic [5:0] imm_v,
                             input int wait_c, input logic [2:0] alu_fl);
        logic       exp_reg_en, exp_imm_sel, taken;
        logic [1:0] exp_op;
        int         code;
        code        = int'(opc);
        exp_reg_en  = (code < 8);
        exp_imm_sel = (code >= 4 && code < 8);
        exp_op      = (code < 8) ? 2'(code % 4) : ((code == 13) ? 2'd1 : 2'd0);
        case (code)
            8:       taken = 1'b1;
            9:       taken = m_flags[1];
            10:      taken = m_flags[0];
            11:      taken = m_flags[2];
            12:      taken = !m_flags[0];
            default: taken = 1'b0;
        endcase

        for (int c = 0; c <= wait_c; c++) begin
            check("fetch_req", 32'(imem_req), 32'd1);
            check("fetch_addr", 32'(imem_addr), 32'(m_pc));
            check("fetch_ctl", 32'({op, imm_sel, reg_en, halted}), 32'd0);
            check("fetch_flags", 32'(flags), 32'(m_flags));
            imem_ack    = (c == wait_c);
            imem_opcode = (c == wait_c) ? opc : 4'($urandom);
            imem_imm    = (c == wait_c) ? imm_v : 6'($urandom);
            @(negedge clk);
        end

        check("decode_req", 32'(imem_req), 32'd0);
        check("decode_ctl", 32'({op, imm_sel, reg_en, halted}), 32'd0);
        check("decode_imm", 32'(imm), 32'(imm_v));
        imem_ack    = 1'($urandom);
        imem_opcode = 4'($urandom);
        imem_imm    = 6'($urandom);
        {alu_cf, alu_sf, alu_zf} = ~alu_fl;
        @(negedge clk);

        check("exec_req", 32'(imem_req), 32'd0);
        check("exec_op", 32'(op), 32'(exp_op));
        check("exec_imm_sel", 32'(imm_sel), 32'(exp_imm_sel));
        check("exec_reg_en", 32'(reg_en), 32'(exp_reg_en));
        check("exec_imm", 32'(imm), 32'(imm_v));
        check("exec_flags", 32'(flags), 32'(m_flags));
        check("exec_halted", 32'(halted), 32'd0);
        {alu_cf, alu_sf, alu_zf} = alu_fl;
        imem_ack = 1'b1;
        if (code >= 8 && code <= 12) begin
            #2 alu_zf = ~alu_zf;
        end
        @(negedge clk);

        if (code < 8 || code == 13) m_flags = alu_fl;
        if (code == 15) m_halted = 1'b1;
        else if (taken) m_pc = imm_v;
        else m_pc = 6'((int'(m_pc) + 1) % 64);
        imem_ack = 1'b0;
    endtask

    // Reset asserted at a falling edge and released one cycle later.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("rst_ctl", 32'({op, imm_sel, reg_en, halted}), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_imm", 32'(imm), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        m_pc     = '0;
        m_flags  = '0;
        m_halted = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{4'b0000, 6'd0,  0, 3'b000, 6'd1,  3'b000};
        tbl[1]  = '{4'b0100, 6'd5,  3, 3'b101, 6'd2,  3'b101};
        tbl[2]  = '{4'b1101, 6'd0,  0, 3'b010, 6'd3,  3'b010};
        tbl[3]  = '{4'b1001, 6'd10, 1, 3'b101, 6'd10, 3'b010};
        tbl[4]  = '{4'b1101, 6'd0,  0, 3'b001, 6'd11, 3'b001};
        tbl[5]  = '{4'b1001, 6'd10, 0, 3'b010, 6'd12, 3'b001};
        tbl[6]  = '{4'b1100, 6'd20, 0, 3'b000, 6'd13, 3'b001};
        tbl[7]  = '{4'b1010, 6'd63, 0, 3'b000, 6'd63, 3'b001};
        tbl[8]  = '{4'b0001, 6'd0,  2, 3'b000, 6'd0,  3'b000};
        tbl[9]  = '{4'b1000, 6'd5,  0, 3'b111, 6'd5,  3'b000};
        tbl[10] = '{4'b1000, 6'd63, 0, 3'b000, 6'd63, 3'b000};
        tbl[11] = '{4'b1010, 6'd7,  2, 3'b001, 6'd0,  3'b000};
        tbl[12] = '{4'b1011, 6'd33, 0, 3'b111, 6'd1,  3'b000};
        tbl[13] = '{4'b0011, 6'd0,  0, 3'b110, 6'd2,  3'b110};
        tbl[14] = '{4'b1011, 6'd33, 1, 3'b000, 6'd33, 3'b110};
        tbl[15] = '{4'b1110, 6'd9,  0, 3'b001, 6'd34, 3'b110};
        tbl[16] = '{4'b0010, 6'd0,  0, 3'b001, 6'd35, 3'b001};
        tbl[17] = '{4'b1000, 6'd35, 0, 3'b000, 6'd35, 3'b001};
        tbl[18] = '{4'b1000, 6'd35, 1, 3'b000, 6'd35, 3'b001};
        tbl[19] = '{4'b1000, 6'd7,  0, 3'b000, 6'd7,  3'b001};
        tbl[20] = '{4'b1111, 6'd0,  0, 3'b111, 6'd7,  3'b001};

        rst_n = 1'b0;
        imem_ack = 1'b0;
        imem_opcode = '0;
        imem_imm = '0;
        {alu_cf, alu_sf, alu_zf} = 3'b000;
        m_pc = '0;
        m_flags = '0;
        m_halted = 1'b0;
        #1;
        check("reset_op", 32'(op), 32'd0);
        check("reset_imm_sel", 32'(imm_sel), 32'd0);
        check("reset_reg_en", 32'(reg_en), 32'd0);
        check("reset_halted", 32'(halted), 32'd0);
        check("reset_flags", 32'(flags), 32'd0);
        check("reset_addr", 32'(imem_addr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            run_instr(tbl[i].opc, tbl[i].imm_v, tbl[i].wait_c, tbl[i].alu_fl);
            check($sformatf("tbl%0d_pc", i), 32'(imem_addr), 32'(tbl[i].exp_pc));
            check($sformatf("tbl%0d_flags", i), 32'(flags), 32'(tbl[i].exp_flags));
            $display("vec %0d: opc=%b imm=%0d wait=%0d -> pc=%0d flags=%b",
                     i, tbl[i].opc, tbl[i].imm_v, tbl[i].wait_c, imem_addr, flags);
        end

        // HALT hold: ack pulses must not restart fetching or move pc.
        for (int c = 0; c < 20; c++) begin
            check("halt_halted", 32'(halted), 32'd1);
            check("halt_req", 32'(imem_req), 32'd0);
            check("halt_pc", 32'(imem_addr), 32'd7);
            check("halt_ctl", 32'({op, imm_sel, reg_en}), 32'd0);
            check("halt_flags", 32'(flags), 32'b001);
            imem_ack = 1'(c % 2);
            imem_opcode = 4'($urandom);
            imem_imm = 6'($urandom);
            @(negedge clk);
        end
        imem_ack = 1'b0;
        $display("halt hold: pc=%0d halted=%0d", imem_addr, halted);

        // Asynchronous reset in the middle of an ALU EXEC cycle.
        do_reset();
        run_instr(4'b1101, 6'd0, 0, 3'b111);
        check("pre_rst_flags", 32'(flags), 32'b111);
        imem_ack = 1'b1;
        imem_opcode = 4'b0000;
        imem_imm = 6'd3;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        check("mid_exec_reg_en", 32'(reg_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reg_en", 32'(reg_en), 32'd0);
        check("async_pc", 32'(imem_addr), 32'd0);
        check("async_flags", 32'(flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = '0;
        m_flags = '0;
        m_halted = 1'b0;
        run_instr(4'b0110, 6'd17, 1, 3'b011);
        $display("reset mid-exec: refetched at 0, now pc=%0d flags=%b", imem_addr, flags);

        for (int i = 0; i < 150; i++) begin
            logic [3:0] r_opc;
            logic [5:0] r_imm;
            logic [2:0] r_fl;
            int         r_w;
            r_opc = 4'($urandom);
            r_imm = 6'($urandom);
            r_fl  = 3'($urandom);
            r_w   = int'($urandom_range(0, 3));
            run_instr(r_opc, r_imm, r_w, r_fl);
            check("rand_pc", 32'(imem_addr), 32'(m_pc));
            check("rand_flags", 32'(flags), 32'(m_flags));
            check("rand_halted", 32'(halted), 32'(m_halted));
            $display("rand %0d: opc=%b imm=%0d wait=%0d -> pc=%0d flags=%b halted=%0d",
                     i, r_opc, r_imm, r_w, imem_addr, flags, halted);
            if (m_halted) begin
                do_reset();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle successor to the combinational control unit of the 6-bit CPU.
- Owns the program counter, fetches instructions over a req/ack handshake and holds the fetched instruction in an internal IR.
- Drives ALU/register-file controls for exactly one cycle per instruction.
- Latches ALU flags into a flag register and evaluates conditional jumps against those latched flags. Adds CMP, NOP and HALT.

Parameters:
- PC_W, 6, program counter and instruction-address width.
- IMM_W, 6, immediate field width; must be >= PC_W; jump target = imm[PC_W-1:0].
- ALU_OP_W, 2, width of the ALU operation select.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request; high throughout FETCH.
- imem_addr  output  PC_W  fetch address; always equals the current pc.
- imem_ack  input  1  instruction valid; sampled only in FETCH.
- imem_opcode  input  4  fetched opcode.
- imem_imm  input  IMM_W  fetched immediate.
- alu_cf, alu_sf, alu_zf  input  1 each  live ALU carry, sign and zero flags.
- op  output  ALU_OP_W  ALU operation select.
- imm_sel  output  1  1 = ALU operand B comes from imm.
- reg_en  output  1  register-file write enable.
- imm  output  IMM_W  IR immediate; valid from DECODE onward.
- flags  output  3  latched {cf, sf, zf}.
- halted  output  1  high while in HALT.

Behaviour:
- Reset (async, rst_n=0) takes effect immediately, even mid-instruction. On reset:
  - state=FETCH, pc=0, IR=0, flags=000.
  - op=0, imm_sel=0, reg_en=0, halted=0.
  - imem_req=1 from the first clock edge after release.
- Opcode map:
  - 0000-0011: reg-reg ALU; op=opcode[1:0]; ADD, SUB, AND, OR.
  - 0100-0111: same ALU ops with immediate operand; imm_sel=1.
  - 1000: JMP.
  - 1001: JS, jump if sf=1.
  - 1010: JZ, jump if zf=1.
  - 1011: JC, jump if cf=1.
  - 1100: JNZ, jump if zf=0.
  - 1101: CMP; op=SUB (01), flags updated, reg_en=0.
  - 1110: NOP.
  - 1111: HALT.
- FSM states: FETCH -> DECODE -> EXEC -> FETCH, plus HALT.
  - FETCH: imem_req=1. On the first rising edge with imem_ack=1, capture opcode and imm into IR, go to DECODE. Otherwise stay.
  - DECODE: one cycle. All control outputs low. Go to EXEC.
  - EXEC: one cycle.
    - ALU ops: reg_en=1 and op/imm_sel driven per map for this cycle only.
    - ALU ops and CMP: at the end of EXEC, flags <= {alu_cf, alu_sf, alu_zf}.
    - Jumps and NOP: reg_en=0 and flags unchanged.
    - pc update: pc <= imm[PC_W-1:0] if the jump is taken, else pc+1 mod 2^PC_W (63 wraps to 0).
    - Next state: HALT if opcode=1111, else FETCH.
  - HALT: halted=1, imem_req=0, pc frozen, all controls low. Exit only via reset.
- Control outputs op, imm_sel and reg_en are 0 in every state except EXEC.
- Latency: 3 cycles per instruction when ack arrives in the first FETCH cycle. Each additional FETCH wait cycle adds 1.
- Jump conditions use the flag register, never the live alu_* inputs. A jump immediately after CMP/ALU sees that instruction's result.
- Jump instructions, NOP and HALT never modify flags.
- imem_ack outside FETCH is ignored. If ack is held high across consecutive fetches, each fetch captures once per FETCH entry.
- Jump to its own address is legal and loops forever.
- HALT pc: HALT does not advance pc; pc holds the HALT instruction's address.

Test Plan:
- Reset, then ADD r (0000) with ack on the first FETCH cycle -> imem_req=1 at pc=0. Two cycles later reg_en=1 and op=00 for exactly 1 cycle. pc=1 on the next FETCH.
- ADDI (0100) with imm=000101 and ack delayed 3 cycles -> imem_req held for 4 cycles. In EXEC: imm_sel=1, op=00, reg_en=1, imm=5. Total 6 cycles.
- CMP (1101) with alu_sf=1, alu_zf=0, then JS imm=001010 -> flags=010 after CMP. JS taken: pc=10. Repeat with alu_sf=0: pc=prev+1 and reg_en never asserted.
- JZ at pc=63 with zf=0 -> pc wraps to 0. JMP imm=111111 from pc=5 -> pc=63. Live alu_zf toggling during the JZ EXEC cycle does not affect the decision.
- HALT (1111) at pc=7 -> halted=1 and imem_req=0 from the following cycle. pc stays 7 for 20 cycles while imem_ack pulses; the pulses have no effect.
- Assert rst_n=0 mid-EXEC of an ALU op -> reg_en drops in the same cycle without a clock edge. pc=0 and flags=000. Fetch resumes at address 0 after release.
